// File: rtl/vend_disp_seq.sv
// vend_disp_seq: seven-segment display manager for the vending machine.
// In normal mode it shows the credit in hex, optionally blanking leading zeros.
// Each event pulse is latched in a per-channel pending mask. Latched events are
// shown in turn, lowest channel first, for HOLD_CYC cycles each.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low reset
//   evt      event request levels; a 0->1 transition requests a display
//   credit   credit value as packed nibbles; the MS nibble is the leftmost digit
//   seg      registered segments; digit k is at [7k+6:7k], bit0=a..bit6=g
//   busy     1 while an event code is being shown
//   cur_evt  one-hot channel being shown, 0 when idle
//   pending  requests latched but not yet shown
module vend_disp_seq #(
  parameter int unsigned NDIG     = 2,
  parameter int unsigned NEVT     = 5,
  parameter int unsigned HOLD_CYC = 6,
  parameter int unsigned LZB      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NEVT-1:0]      evt,
  input  logic [4*NDIG-1:0]    credit,
  output logic [7*NDIG-1:0]    seg,
  output logic                 busy,
  output logic [NEVT-1:0]      cur_evt,
  output logic [NEVT-1:0]      pending
);

  localparam int unsigned SW  = 7 * NDIG;
  localparam int unsigned HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYC - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  // Hex digit to active-high segments (bit0=a .. bit6=g).
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [0:0]      state_q, state_d;
  logic [NEVT-1:0] pending_q, pending_d;
  logic [NEVT-1:0] cur_evt_q, cur_evt_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [NEVT-1:0] evt_d_q, evt_d_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic            busy_q, busy_d;

  logic [NEVT-1:0] rise_c;
  logic [NEVT-1:0] grant_c;
  logic            accept_c;
  logic [3:0]      code_c;
  logic            seen_nz_c;
  logic [3:0]      nib_c;

  // State register; reset discards in-flight and pending events.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      cur_evt_q  <= '0;
      hold_cnt_q <= '0;
      evt_d_q    <= '0;
      seg_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cur_evt_q  <= cur_evt_d;
      hold_cnt_q <= hold_cnt_d;
      evt_d_q    <= evt_d_d;
      seg_q      <= seg_d;
      busy_q     <= busy_d;
    end
  end

  // Rising-edge detect and lowest-index-first arbitration over registered pending.
  assign rise_c  = evt & ~evt_d_q;
  assign grant_c = pending_q & (~pending_q + NEVT'(1));

  // Next-state logic: sequencing, pending bookkeeping, busy.
  always_comb begin
    state_d    = state_q;
    cur_evt_d  = cur_evt_q;
    hold_cnt_d = hold_cnt_q;
    accept_c   = 1'b0;
    evt_d_d    = evt;

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d  = S_SHOW;
          accept_c = 1'b1;
        end
      end
      S_SHOW: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HCW'(1);
        end else if (|pending_q) begin
          accept_c = 1'b1;
        end else begin
          state_d   = S_IDLE;
          cur_evt_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cur_evt_d = '0;
      end
    endcase

    if (accept_c) begin
      cur_evt_d  = grant_c;
      hold_cnt_d = HOLD_LOAD;
    end

    // A rise on the channel granted this cycle re-sets its bit, so it replays.
    pending_d = (pending_q & ~(accept_c ? grant_c : '0)) | rise_c;
    busy_d    = (state_d == S_SHOW);
  end

  // Segment source from the current state: event code or credit.
  always_comb begin
    seg_d     = '0;
    code_c    = '0;
    seen_nz_c = 1'b0;
    nib_c     = '0;

    for (int i = 0; i < int'(NEVT); i++) begin
      if (cur_evt_q[i]) code_c = code_c | 4'(10 + i);
    end

    if (state_q == S_SHOW) begin
      for (int k = 0; k < int'(NDIG); k++) begin
        seg_d[7*k +: 7] = hex7(code_c);
      end
    end else begin
      // Walk from the MS digit down; a zero is blanked until a nonzero is seen.
      for (int k = int'(NDIG) - 1; k >= 0; k--) begin
        nib_c = credit[4*k +: 4];
        if ((nib_c != 4'h0) || (k == 0) || (LZB == 0) || seen_nz_c) begin
          seg_d[7*k +: 7] = hex7(nib_c);
        end
        if (nib_c != 4'h0) seen_nz_c = 1'b1;
      end
    end
  end

  assign seg     = seg_q;
  assign busy    = busy_q;
  assign cur_evt = cur_evt_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_vend_disp_seq.sv
// Testbench for vend_disp_seq with the default parameters.
// It runs directed scenarios and then random stimulus. Every cycle it checks
// the DUT against a behavioural model that keeps the pending requests as a set
// and the shown event as a channel number plus a count of remaining cycles.
module tb_vend_disp_seq;

  localparam int NDIG = 2;
  localparam int NEVT = 5;
  localparam int HOLD = 6;
  localparam int LZB  = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NEVT-1:0]   evt;
  logic [4*NDIG-1:0] credit;
  logic [7*NDIG-1:0] seg;
  logic              busy;
  logic [NEVT-1:0]   cur_evt;
  logic [NEVT-1:0]   pending;

  vend_disp_seq #(.NDIG(NDIG), .NEVT(NEVT), .HOLD_CYC(HOLD), .LZB(LZB)) dut (
    .clk(clk), .reset(reset), .evt(evt), .credit(credit),
    .seg(seg), .busy(busy), .cur_evt(cur_evt), .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: channel on screen (-1 = credit), cycles left, pending set.
  int                m_cur  = -1;
  int                m_left = 0;
  bit [NEVT-1:0]     m_pend = '0;
  bit [NEVT-1:0]     m_prev = '0;
  logic [7*NDIG-1:0] m_seg  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7*NDIG-1:0] disp(input int cur, input logic [4*NDIG-1:0] cr);
    logic [7*NDIG-1:0] r;
    int ms;
    r  = '0;
    ms = 0;
    for (int k = 0; k < NDIG; k++) if (cr[4*k +: 4] != 4'h0) ms = k;
    for (int k = 0; k < NDIG; k++) begin
      if (cur >= 0)                 r[7*k +: 7] = hex_tab[10 + cur];
      else if (LZB == 0 || k <= ms) r[7*k +: 7] = hex_tab[cr[4*k +: 4]];
    end
    return r;
  endfunction

  task automatic take_lowest();
    for (int i = 0; i < NEVT; i++) begin
      if (m_pend[i]) begin
        m_cur     = i;
        m_pend[i] = 1'b0;
        m_left    = HOLD;
        return;
      end
    end
  endtask

  // One clock edge: advance the model with the inputs sampled there, then compare.
  task automatic tick();
    bit [NEVT-1:0] rise;
    logic [31:0]   exp_cur;
    @(posedge clk);
    if (!reset) begin
      m_cur = -1; m_left = 0; m_pend = '0; m_prev = '0; m_seg = '0;
    end else begin
      m_seg  = disp(m_cur, credit);
      rise   = evt & ~m_prev;
      m_prev = evt;
      if (m_cur < 0) begin
        if (m_pend != '0) take_lowest();
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_pend != '0) take_lowest();
          else m_cur = -1;
        end
      end
      m_pend |= rise;
    end
    #1;
    exp_cur = (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0;
    chk("seg",     32'(seg),     32'(m_seg));
    chk("busy",    32'(busy),    32'(m_cur >= 0));
    chk("cur_evt", 32'(cur_evt), exp_cur);
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int n_a, n_b;
  logic [7*NDIG-1:0] pat;

  initial begin
    reset  = 1'b0;
    evt    = '0;
    credit = 8'h05;

    // Reset, then credit display with leading-zero blanking.
    ticks(2);
    chk("rst_seg", 32'(seg), 32'd0);
    reset = 1'b1;
    tick();
    chk("credit_05", 32'(seg), 32'({7'h00, 7'h6D}));
    credit = 8'h25;
    tick();
    chk("credit_25", 32'(seg), 32'({7'h5B, 7'h6D}));

    // Single event on channel 0: six cycles of "A A".
    evt = 5'b00001;
    tick();
    evt = '0;
    tick();
    chk("single_busy", 32'(busy), 32'd1);
    n_a = 0;
    pat = {7'h77, 7'h77};
    for (int i = 0; i < 10; i++) begin
      tick();
      if (seg == pat) n_a++;
    end
    chk("single_len", 32'(n_a), 32'd6);

    // Simultaneous events 1 and 4, shown back to back.
    evt = 5'b10010;
    tick();
    evt = '0;
    chk("simul_pend0", 32'(pending), 32'(5'b10010));
    tick();
    chk("simul_pend1", 32'(pending), 32'(5'b10000));
    n_a = 0; n_b = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (seg == {7'h7C, 7'h7C}) n_a++;
      if (seg == {7'h79, 7'h79}) n_b++;
    end
    chk("simul_len1", 32'(n_a), 32'd6);
    chk("simul_len4", 32'(n_b), 32'd6);

    // Merge a double pulse on channel 3; replay channel 2.
    evt = 5'b00100; tick(); evt = '0; ticks(2);
    evt = 5'b01000; tick(); evt = '0; tick();
    evt = 5'b01000; tick(); evt = '0; tick();
    evt = 5'b00100; tick(); evt = '0;
    n_a = 0; n_b = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (seg == {7'h5E, 7'h5E}) n_a++;
      if (seg == {7'h39, 7'h39}) n_b++;
    end
    chk("merge_len3", 32'(n_a), 32'd6);
    chk("replay_len2", 32'(n_b), 32'd6);

    // Reset during SHOW with channel 3 pending.
    evt = 5'b00100; tick(); evt = '0; ticks(2);
    evt = 5'b01000; tick(); evt = '0; tick();
    chk("pre_rst_pend", 32'(pending), 32'(5'b01000));
    reset = 1'b0;
    tick();
    chk("midrst_pend", 32'(pending), 32'd0);
    chk("midrst_seg",  32'(seg),     32'd0);
    chk("midrst_busy", 32'(busy),    32'd0);
    reset = 1'b1;
    n_a = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) n_a++;
    end
    chk("no_replay", 32'(n_a), 32'd0);

    // Level held across reset release: exactly one "E E" display.
    reset = 1'b0;
    evt   = 5'b10000;
    ticks(2);
    reset = 1'b1;
    n_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (seg == {7'h79, 7'h79}) n_a++;
    end
    chk("level_once", 32'(n_a), 32'd6);
    evt = '0;
    tick();

    // Random traffic: sparse toggles, changing credit, occasional reset.
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < NEVT; b++) begin
        if ($urandom_range(0, 9) == 0) evt[b] = ~evt[b];
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       credit = 8'h00;
          1:       credit = 8'(($urandom_range(0, 15)));
          default: credit = 8'($urandom);
        endcase
      end
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_disp_seq.md
Name: vend_disp_seq

Overview:
- Parametrised successor to the vending-machine two-digit display manager.
- Drives NDIG active-high seven-segment digits. In normal mode it shows the credit in hex, with optional leading-zero blanking.
- On an event pulse (item vended, error, ...) it shows that event's code for HOLD_CYC cycles.
- Events arriving while a code is on screen are held in a per-channel pending mask and shown in turn, lowest index first. No event is lost.

Parameters:
- NDIG, 2, number of display digits (1..4); credit width is 4*NDIG.
- NEVT, 5, number of event channels (1..6). Channel i code nibble = 0xA+i, repeated on every digit.
- HOLD_CYC, 6, cycles each event code stays in the SHOW state (>=1).
- LZB, 1, 1 = blank leading zero digits in credit mode; 0 = show all digits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low.
- evt  in  NEVT  event request levels; a rising edge (0->1 between samples) requests display.
- credit  in  4*NDIG  credit value, packed nibbles; the MS nibble is the leftmost digit.
- seg  out  7*NDIG  registered segments; digit k occupies [7k+6:7k], bit0=a ... bit6=g, 1 = lit.
- busy  out  1  1 while state = SHOW.
- cur_evt  out  NEVT  one-hot channel being shown; 0 in IDLE.
- pending  out  NEVT  outstanding requests not yet shown.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, pending=0, cur_evt=0, busy=0, hold_cnt=0, evt_d=0, seg=0 (all blank). Reset overrides everything, including mid-SHOW; in-flight and pending events are discarded.
- Edge detect: rise = evt & ~evt_d; evt_d <= evt every cycle. A level held high through reset release produces exactly one rise on the first active cycle.
- Pending update each cycle: pending <= (pending & ~grant) | rise. grant is the one-hot channel accepted this cycle, or 0.
  - A rise on a channel already pending merges; it is not counted twice.
  - A rise on the channel being granted that same cycle leaves its bit set, so the event replays.
- Arbiter: grant = lowest set bit of the registered pending. A rise in the current cycle is not eligible until the next cycle.
- FSM IDLE:
  - If pending != 0: state<=SHOW, cur_evt<=grant, hold_cnt<=HOLD_CYC-1.
  - Else stay IDLE.
- FSM SHOW:
  - If hold_cnt != 0: hold_cnt<=hold_cnt-1.
  - Else if pending != 0: back-to-back grant; reload cur_evt and hold_cnt, stay SHOW.
  - Else state<=IDLE, cur_evt<=0.
- Each granted event spends exactly HOLD_CYC cycles in SHOW.
- Latency: rise sampled at edge t -> pending set at t -> SHOW at t+1 -> seg shows the code at t+2. seg is registered from the current-state source, so it lags state by one cycle.
- seg source:
  - SHOW: every digit = hex7(0xA+index(cur_evt)).
  - IDLE: digit k = hex7(credit nibble k). If LZB=1, each zero nibble above every nonzero higher nibble is blanked (0x00). Digit 0 is never blanked, so credit 0 shows a single "0".
- hex7 table, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- credit is sampled every IDLE cycle; a change appears on seg one edge later. credit changes during SHOW are not displayed until the return to IDLE.
- busy = (state==SHOW), registered together with state.

Test Plan:
- Reset and credit display, defaults, LZB=1: hold reset=0 for 2 cycles, seg=0. Release with credit=8'h05 -> seg digit1=00, digit0=6D. Set credit=8'h25 -> next edge digit1=5B, digit0=6D.
- Single event: pulse evt[0] for 1 cycle at edge t -> busy=1 at t+1, seg=77,77 from t+2 for exactly 6 cycles. At t+7 busy=0, and at t+8 seg shows credit again.
- Simultaneous events: evt=5'b10010 rising together -> channel 1 shown (7C) for 6 cycles, then channel 4 (79) back-to-back with no credit cycle between. pending goes 10010 -> 10000 -> 00000.
- Merge and replay: during channel-2 SHOW, pulse evt[3] twice (shown once, 5E). Re-pulse evt[2] mid-SHOW -> channel 2 (39) is shown again after channel 3.
- Reset mid-operation: assert reset during SHOW with pending=01000 -> next edge state IDLE, pending=0, seg=0. After release, seg shows credit and nothing replays unless a new rise arrives.
- Level held through reset: evt[4]=1 across reset deassertion -> exactly one E display (79). A continued high level produces no further events.
